// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-source scheduler.
package disp_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    FROZEN = 2'd2
  } disp_state_e;

  localparam logic [1:0] SRC_LED    = 2'd0;
  localparam logic [1:0] SRC_ALL    = 2'd1;
  localparam logic [1:0] SRC_JMP    = 2'd2;
  localparam logic [1:0] SRC_BRANCH = 2'd3;

  // Switch codes 4-7 fold back onto the LED source.
  function automatic logic [1:0] map_sel(input logic [2:0] s);
    return s[2] ? SRC_LED : s[1:0];
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for auto-rotation: pulses expire on the last cycle of each dwell.
module dwell_timer #(
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic run,
  input  logic restart,
  output logic expire
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt;

  // A restarting edge counts as cycle 0 of a fresh dwell, so it never expires.
  assign expire = run && !restart && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (clr)          cnt <= '0;
    else if (restart) cnt <= run ? CW'(1) : '0;
    else if (run)     cnt <= expire ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/disp_src_sched.sv
// Chooses which CPU statistic drives the 7-segment display: manual, auto-rotate or frozen.
module disp_src_sched
  import disp_pkg::*;
#(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int DW           = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          auto_en,
  input  logic          freeze,
  input  logic [2:0]    sel,
  input  logic [DW-1:0] src_led,
  input  logic [DW-1:0] src_all,
  input  logic [DW-1:0] src_jmp,
  input  logic [DW-1:0] src_branch,
  output logic [DW-1:0] show_data,
  output logic [1:0]    show_idx,
  output logic          src_switch
);

  disp_state_e       state_q, mode;
  logic [3:0][DW-1:0] srcs;
  logic [1:0]        idx_nxt;
  logic [DW-1:0]     data_nxt;
  logic              run, restart, expire;

  assign srcs = {src_branch, src_jmp, src_all, src_led};

  // Mode acts on the edge it is sampled; state_q only remembers the previous mode.
  always_comb begin
    mode = MANUAL;
    if (freeze)       mode = FROZEN;
    else if (auto_en) mode = AUTO;
  end

  assign run     = (mode == AUTO);
  assign restart = (mode == MANUAL) || (state_q == FROZEN && mode != FROZEN);

  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_dwell (
    .clk     (clk),
    .clr     (clr),
    .run     (run),
    .restart (restart),
    .expire  (expire)
  );

  always_comb begin
    idx_nxt  = show_idx;
    data_nxt = show_data;
    case (mode)
      MANUAL: begin
        idx_nxt  = map_sel(sel);
        data_nxt = srcs[idx_nxt];
      end
      AUTO: begin
        if (expire) idx_nxt = show_idx + 2'd1;
        data_nxt = srcs[idx_nxt];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= MANUAL;
      show_idx   <= SRC_LED;
      show_data  <= '0;
      src_switch <= 1'b0;
    end else begin
      state_q    <= mode;
      show_idx   <= idx_nxt;
      show_data  <= data_nxt;
      src_switch <= (idx_nxt != show_idx);
    end
  end

endmodule

// File: tb/tb_disp_src_sched.sv
// Directed bench for disp_src_sched with a cycle-level reference model.
module tb_disp_src_sched;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        clr, auto_en, freeze;
  logic [2:0]  sel;
  logic [31:0] src_led, src_all, src_jmp, src_branch;
  logic [31:0] show_data;
  logic [1:0]  show_idx;
  logic        src_switch;

  int errors = 0;
  int checks = 0;

  disp_src_sched #(.DWELL_CYCLES(D), .DW(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .auto_en    (auto_en),
    .freeze     (freeze),
    .sel        (sel),
    .src_led    (src_led),
    .src_all    (src_all),
    .src_jmp    (src_jmp),
    .src_branch (src_branch),
    .show_data  (show_data),
    .show_idx   (show_idx),
    .src_switch (src_switch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: tracks elapsed cycles of the current dwell (1..D).
  bit          m_valid = 0;
  int          m_el, m_prev, md;
  logic [1:0]  m_idx, ni;
  logic [31:0] m_data;
  logic        m_sw;

  function automatic logic [31:0] src_of(input logic [1:0] i);
    case (i)
      2'd0:    return src_led;
      2'd1:    return src_all;
      2'd2:    return src_jmp;
      default: return src_branch;
    endcase
  endfunction

  always @(posedge clk) begin
    md = freeze ? 2 : (auto_en ? 1 : 0);
    if (clr) begin
      m_idx = 0; m_data = 0; m_sw = 0; m_el = 0; m_prev = 0; m_valid = 1;
    end else begin
      ni = m_idx;
      if (md == 0) begin
        ni   = (sel < 3'd4) ? sel[1:0] : 2'd0;
        m_el = 0;
      end else if (md == 1) begin
        if (m_prev == 2) m_el = 0;
        m_el++;
        if (m_el == D) begin
          m_el = 0;
          ni   = 2'((int'(m_idx) + 1) % 4);
        end
      end
      m_sw = (ni != m_idx);
      if (md != 2) m_data = src_of(ni);
      m_idx  = ni;
      m_prev = md;
    end
    #1;
    if (m_valid) begin
      chk("model show_data", 64'(show_data), 64'(m_data));
      chk("model show_idx", 64'(show_idx), 64'(m_idx));
      chk("model src_switch", 64'(src_switch), 64'(m_sw));
    end
  end

  int          sw_cyc[$];
  int          first_sw;
  logic [31:0] held;

  initial begin
    clr = 1; auto_en = 0; freeze = 0; sel = 0;
    src_led = 32'h11; src_all = 32'h22; src_jmp = 32'h33; src_branch = 32'h44;

    // Reset held two cycles
    repeat (2) @(negedge clk);
    chk("reset data", 64'(show_data), 64'h0);
    chk("reset idx", 64'(show_idx), 64'h0);
    chk("reset switch", 64'(src_switch), 64'h0);
    clr = 0;
    @(negedge clk);
    chk("post-reset led", 64'(show_data), 64'h11);
    chk("post-reset switch", 64'(src_switch), 64'h0);

    // Manual select
    src_jmp = 32'h0000_0042; sel = 3'd2;
    @(negedge clk);
    chk("manual data", 64'(show_data), 64'h42);
    chk("manual idx", 64'(show_idx), 64'h2);
    chk("manual switch", 64'(src_switch), 64'h1);
    @(negedge clk);
    chk("manual switch drop", 64'(src_switch), 64'h0);
    sel = 3'd6;
    @(negedge clk);
    chk("sel6 idx", 64'(show_idx), 64'h0);
    chk("sel6 data", 64'(show_data), 64'h11);

    // Auto rotation from idx 0
    auto_en = 1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (src_switch) sw_cyc.push_back(c);
    end
    chk("rotate count", 64'(sw_cyc.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < sw_cyc.size()) chk("rotate cycle", 64'(sw_cyc[i]), 64'(4 * (i + 1)));
    chk("rotate wrap idx", 64'(show_idx), 64'h0);
    repeat (4) @(negedge clk);
    chk("rotate idx1", 64'(show_idx), 64'h1);

    // Live tracking on idx 1
    for (int i = 0; i < 3; i++) begin
      src_all = src_all + 32'd1;
      @(negedge clk);
      chk("live data", 64'(show_data), 64'(src_all));
    end

    // Freeze one cycle before expiry
    freeze = 1;
    held   = src_all;
    for (int i = 0; i < 10; i++) begin
      src_all = src_all + 32'd5; src_jmp = src_jmp + 32'd3; src_led = src_led ^ 32'hff;
      @(negedge clk);
      chk("freeze data", 64'(show_data), 64'(held));
      chk("freeze idx", 64'(show_idx), 64'h1);
    end
    freeze   = 0;
    first_sw = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (src_switch && first_sw == 0) first_sw = c;
      if (c == 4) chk("resume idx", 64'(show_idx), 64'h2);
    end
    chk("resume delay", 64'(first_sw), 64'd4);
    chk("resume idx3", 64'(show_idx), 64'h3);

    // Reset during FROZEN on idx 3
    freeze = 1;
    repeat (2) @(negedge clk);
    clr = 1;
    @(negedge clk);
    chk("midreset idx", 64'(show_idx), 64'h0);
    chk("midreset data", 64'(show_data), 64'h0);
    chk("midreset switch", 64'(src_switch), 64'h0);
    clr = 0;
    repeat (2) @(negedge clk);
    chk("frozen after reset data", 64'(show_data), 64'h0);
    chk("frozen after reset idx", 64'(show_idx), 64'h0);
    freeze = 0; auto_en = 0; sel = 3'd3;
    @(negedge clk);
    chk("final idx", 64'(show_idx), 64'h3);
    chk("final switch", 64'(src_switch), 64'h1);
    chk("final data", 64'(show_data), 64'(src_branch));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_src_sched.md
# disp_src_sched

Display-source scheduler between the CPU statistics outputs and the 7-segment scan driver. It selects which 32-bit value is shown from four sources: program LED data, total instruction count, jump count and branch count. Selection is manual from switches, automatic rotation with a programmable dwell time, or frozen on a snapshot. Its registered output feeds the `show` driver directly, replacing the free-running combinational select in the top level.

## Interface
- `DWELL_CYCLES`, default 100_000_000: clk cycles each source stays shown in auto mode; legal range ≥ 2.
- `DW`, default 32: source and output data width.

- `clk`  in  1: system clock, the undivided board clock.
- `clr`  in  1: reset, synchronous and active-high.
- `auto_en`  in  1: level; 1 selects auto-rotation.
- `freeze`  in  1: level; 1 holds the current output snapshot. Highest priority.
- `sel`  in  3: manual source select.
  - 0 selects LED data, 1 total count, 2 jump count, 3 branch count.
  - 4–7 map to 0.
- `src_led`  in  DW: CPU LED data.
- `src_all`  in  DW: total instruction count.
- `src_jmp`  in  DW: jump count.
- `src_branch`  in  DW: branch count.
- `show_data`  out  DW: registered value to the display.
- `show_idx`  out  2: registered index of the source currently shown.
- `src_switch`  out  1: one-cycle pulse when `show_idx` changes.

## Operation
- **State machine:** states MANUAL, AUTO and FROZEN. The state is re-evaluated every cycle in this priority order:
  - `freeze`=1 → FROZEN;
  - otherwise `auto_en`=1 → AUTO;
  - otherwise → MANUAL.
- **MANUAL:**
  - `show_idx` ← mapped `sel`.
  - `show_data` ← source[mapped `sel`].
  - Dwell counter held at 0.
- **AUTO:**
  - `show_idx` holds its value; the dwell counter increments every cycle.
  - When the counter equals `DWELL_CYCLES`−1, the counter returns to 0 and `show_idx` advances 0→1→2→3→0 (wraps 3→0).
  - `show_data` ← source[`show_idx` after update] every cycle, so a live counter value is tracked while it is displayed.
- **Entering AUTO from MANUAL:**
  - Rotation starts from the current `show_idx`.
  - Counter starts at 0, so the first dwell is a full `DWELL_CYCLES` cycles.
- **FROZEN:**
  - `show_data`, `show_idx` and the counter all hold.
  - Source changes are ignored.
- **Leaving FROZEN:**
  - Go to AUTO or MANUAL according to `auto_en`.
  - Dwell counter restarts at 0.
  - AUTO resumes from the held `show_idx`.
- **src_switch:**
  - Asserted for exactly one cycle whenever the registered `show_idx` differs from its value in the previous cycle.
  - Never asserted in the cycle `clr` is high, nor in the first cycle after reset.
- **Counter width:** $clog2(`DWELL_CYCLES`) bits, unsigned. The counter never exceeds `DWELL_CYCLES`−1.

## Timing
- **Reset (`clr`=1 at a `clk` edge):** state MANUAL, `show_idx`=0, `show_data`=0, counter=0, `src_switch`=0. Reset mid-dwell or mid-freeze discards all progress.
- **Latency:**
  - Source-value change → `show_data`: 1 cycle (MANUAL or AUTO).
  - `sel` change → `show_idx`/`show_data`: 1 cycle.
  - `src_switch` coincides with the cycle in which the new `show_idx` is visible.
- **Mode-input latency:**
  - `freeze` rising at edge k: the value registered at edge k−1 is held from edge k onward.
  - `freeze` and `auto_en` both changing in the same cycle: `freeze` wins.
- **Rotation period:**
  - With `auto_en` held and no freeze, `show_idx` changes every `DWELL_CYCLES` cycles exactly.
  - `src_switch` pulses at the same period.
- **Dwell expiry colliding with `freeze`:** the advance does not happen.
- **Output registering:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `disp_pkg` holds:
  - the state enum (MANUAL, AUTO, FROZEN);
  - source index constants `SRC_LED`=0, `SRC_ALL`=1, `SRC_JMP`=2, `SRC_BRANCH`=3;
  - the `sel` mapping function.
- One sub-module, `dwell_timer`:
  - parameterized by `DWELL_CYCLES`;
  - inputs: `clk`, `clr`, `run`, `restart`;
  - output: one-cycle `expire` pulse.
- The FSM, source mux and output registers stay in `disp_src_sched`.
- The top level instantiates `disp_src_sched` between the CPU and `show`, driving `auto_en` and `freeze` from spare switches.

## Test plan
- **Reset:** assert `clr` 2 cycles with sources nonzero → `show_data`=0, `show_idx`=0, `src_switch`=0; first post-reset cycle shows `src_led`.
- **Manual select:** MANUAL, `src_jmp`=32'h0000_0042, `sel`=2 → next cycle `show_data`=32'h0000_0042, `show_idx`=2, `src_switch`=1 for one cycle; `sel`=6 → `show_idx`=0.
- **Auto rotation:** `DWELL_CYCLES`=4, `auto_en`=1 from idx 0 → idx sequence 1, 2, 3, 0 at cycles 4, 8, 12, 16; `src_switch` pulses exactly at those cycles.
- **Live tracking:** AUTO on idx 1 while `src_all` increments each cycle → `show_data` equals `src_all` delayed by 1 cycle.
- **Freeze:** freeze asserted 1 cycle before a dwell expiry, held 10 cycles, sources changing → outputs constant, no advance. Release with `auto_en`=1 → next advance exactly 4 cycles later.
- **Reset mid-operation:** `clr` pulsed during FROZEN on idx 3 → state MANUAL, idx 0, `show_data`=0; freeze still high next cycle → holds 0.
